// File: rtl/spi_phy_pkg.sv
// ---------------------------------------------------------------------------
// spi_phy_pkg
// Shared definitions for the SPI slave PHYs (receive and transmit sides).
//   spi_state_e     : receiver state (IDLE, RECV)
//   MODE0..MODE3    : SPI mode encoding as {ACTIVE (CPOL), PHASE (CPHA)}
//   BIT_CNT_W       : width of the per-frame sample-edge counter
//   sample_on_rise(): 1 when the mode samples on the rising sck edge
// ---------------------------------------------------------------------------
package spi_phy_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } spi_state_e;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam int unsigned BIT_CNT_W = 24;

  // Modes 0 and 3 sample on the rising sck edge, modes 1 and 2 on the falling.
  function automatic logic sample_on_rise(input logic [1:0] mode);
    logic rise;
    case (mode)
      MODE0, MODE3: rise = 1'b1;
      MODE1, MODE2: rise = 1'b0;
      default:      rise = 1'b1;
    endcase
    return rise;
  endfunction

endpackage : spi_phy_pkg

// File: rtl/spi_sync_edge.sv
// ---------------------------------------------------------------------------
// spi_sync_edge
// Three-flop synchroniser for one asynchronous pin with edge pulses.
// s1/s2 form the metastability chain; s3 is the previous synced value.
// Ports:
//   clock  : local clock
//   rst    : asynchronous, active-high reset (flops load RESET_VAL)
//   din    : asynchronous input pin
//   level  : synchronised level (s2)
//   rise   : 1-cycle pulse, synced level went 0 -> 1
//   fall   : 1-cycle pulse, synced level went 1 -> 0
// Parameter RESET_VAL should equal the pin's idle level so that leaving
// reset never manufactures an edge.
// ---------------------------------------------------------------------------
module spi_sync_edge #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour, giving a true shift chain.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      s1 <= RESET_VAL;
      s2 <= RESET_VAL;
      s3 <= RESET_VAL;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule : spi_sync_edge

// File: rtl/spi_rx_byte_phy.sv
// ---------------------------------------------------------------------------
// spi_rx_byte_phy
// SPI slave receive PHY: synchronises sck/cs_n/mosi into `clock`, detects
// the mode-correct sampling edge and deserialises MOSI into DATA_WIDTH-bit
// words offered on a valid/ready handshake.
//
// Parameters:
//   PHASE      : CPHA, 0 = sample on leading edge, 1 = on trailing edge
//   ACTIVE     : CPOL, 0 = sck idles low, 1 = sck idles high
//   DATA_WIDTH : bits per word (2..32)
// Ports:
//   clock, rst : clock (>= 4x sck) and asynchronous active-high reset
//   sck, cs_n, mosi : asynchronous SPI pins
//   rx_data / rx_valid / rx_ready : received word handshake
//   overrun    : 1-cycle pulse, completed word dropped (output still full)
//   frame_err  : 1-cycle pulse, cs_n rose with a partial word pending
//   bit_cnt    : sample edges seen since cs_n fell (wraps at 2^24)
//   idle       : 1 while the receiver is in IDLE
// Build option:
//   SPI_RX_LSB_FIRST_EN defined -> LSB first (first bit lands in rx_data[0]);
//   undefined -> MSB first. Timing is identical in both builds.
// Latency: sck pin edge to rx_data/rx_valid is 4 clocks
//   (2 sync + 1 detect/shift + 1 output load).
// ---------------------------------------------------------------------------
module spi_rx_byte_phy
  import spi_phy_pkg::*;
#(
  parameter bit PHASE      = 1'b0,
  parameter bit ACTIVE     = 1'b0,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  sck,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  overrun,
  output logic                  frame_err,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  idle
);

  localparam bit               SAMPLE_RISE = sample_on_rise({ACTIVE, PHASE});
  localparam int               IDX_W       = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(DATA_WIDTH - 1);

  // ---------------------------------------------------------------- sync
  logic sck_rise, sck_fall, unused_sck_level;
  logic cs_level, cs_fall, unused_cs_rise;
  logic mosi_s1, mosi_s2;
  logic sample_edge;

  spi_sync_edge #(.RESET_VAL(ACTIVE)) u_sck_sync (
    .clock (clock),
    .rst   (rst),
    .din   (sck),
    .level (unused_sck_level),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  // The end of a frame is taken from the cs_n level, so its rise pulse is
  // not needed.
  spi_sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
    .clock (clock),
    .rst   (rst),
    .din   (cs_n),
    .level (cs_level),
    .rise  (unused_cs_rise),
    .fall  (cs_fall)
  );

  // mosi only needs the two-flop chain; it lines up with the sck detect
  // cycle because both pass through the same two stages.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  assign sample_edge = SAMPLE_RISE ? sck_rise : sck_fall;

  // ------------------------------------------------------- deserialiser
  spi_state_e              state_q, state_d;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_d, shreg_shifted;
  logic [IDX_W-1:0]        bit_idx_q, bit_idx_d;
  logic [BIT_CNT_W-1:0]    bit_cnt_d;
  logic                    frame_err_d;
  logic                    done_q, done_d;

`ifdef SPI_RX_LSB_FIRST_EN
  assign shreg_shifted = {mosi_s2, shreg_q[DATA_WIDTH-1:1]};
`else
  assign shreg_shifted = {shreg_q[DATA_WIDTH-2:0], mosi_s2};
`endif

  // NOTE: every signal driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_idx_d   = bit_idx_q;
    bit_cnt_d   = bit_cnt;
    frame_err_d = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Sample edges are ignored here; bit_cnt keeps the last frame's count.
        bit_idx_d = '0;
        if (cs_fall) begin
          state_d   = RECV;
          bit_cnt_d = '0;
        end
      end

      RECV: begin
        if (cs_level) begin
          // Partial word is discarded; a completed word already handed to
          // the output stage is unaffected.
          state_d     = IDLE;
          bit_idx_d   = '0;
          frame_err_d = (bit_idx_q != '0);
        end else if (sample_edge) begin
          shreg_d   = shreg_shifted;
          bit_cnt_d = bit_cnt + 1'b1;
          if (bit_idx_q == LAST_IDX) begin
            bit_idx_d = '0;
            done_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: the shift register is a handful of flops, not a memory, so it is
  // reset along with the rest of the state for a deterministic rx_data.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      bit_cnt   <= '0;
      frame_err <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      bit_cnt   <= bit_cnt_d;
      frame_err <= frame_err_d;
      done_q    <= done_d;
    end
  end

  assign idle = (state_q == IDLE);

  // -------------------------------------------------------- output stage
  // done_q marks the completion cycle. shreg_q still holds the word then,
  // since the next sample edge is at least 4 clocks away.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done_q) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg_q;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule : spi_rx_byte_phy

// File: tb/tb_spi_rx_byte_phy.sv
// ---------------------------------------------------------------------------
// tb_spi_rx_byte_phy
// Bench for spi_rx_byte_phy. The primary instance runs mode 0 with the
// handshake under bench control; three extra instances (modes 1..3, always
// ready) share the same pins for the mode sweep. sck runs at clock/8.
// Expected words are pushed when a byte is driven and popped when the DUT
// presents a new word. Build with SPI_RX_LSB_FIRST_EN to check the
// LSB-first variant against the same wire sequences.
// ---------------------------------------------------------------------------
module tb_spi_rx_byte_phy;

  logic        clock;
  logic        rst;
  logic        sck_base;
  logic        cs_n;
  logic        mosi0;   // data for PHASE=0 receivers (stable around leading edge)
  logic        mosi1;   // data for PHASE=1 receivers (stable around trailing edge)
  logic        rx_ready;

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        overrun;
  logic        frame_err;
  logic [23:0] bit_cnt;
  logic        idle;

  logic [7:0]  aux_data  [1:3];
  logic        aux_valid [1:3];
  logic        aux_ovr   [1:3];
  logic        aux_ferr  [1:3];
  logic [23:0] aux_cnt   [1:3];
  logic        aux_idle  [1:3];

  int          checks;
  int          failures;
  int          overrun_n;
  int          frame_err_n;
  int          aux_n   [1:3];
  int          aux_bad [1:3];
  bit          aux_on;
  logic [7:0]  exp_q [$];
  logic [7:0]  aux_exp [$];

  spi_rx_byte_phy #(.PHASE(1'b0), .ACTIVE(1'b0), .DATA_WIDTH(8)) u_dut (
    .clock     (clock),
    .rst       (rst),
    .sck       (sck_base),
    .cs_n      (cs_n),
    .mosi      (mosi0),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .overrun   (overrun),
    .frame_err (frame_err),
    .bit_cnt   (bit_cnt),
    .idle      (idle)
  );

  for (genvar m = 1; m <= 3; m++) begin : g_aux
    localparam bit A = (m >= 2);
    localparam bit P = (m % 2 == 1);
    spi_rx_byte_phy #(.PHASE(P), .ACTIVE(A), .DATA_WIDTH(8)) u_aux (
      .clock     (clock),
      .rst       (rst),
      .sck       (sck_base ^ A),
      .cs_n      (cs_n),
      .mosi      (P ? mosi1 : mosi0),
      .rx_data   (aux_data[m]),
      .rx_valid  (aux_valid[m]),
      .rx_ready  (1'b1),
      .overrun   (aux_ovr[m]),
      .frame_err (aux_ferr[m]),
      .bit_cnt   (aux_cnt[m]),
      .idle      (aux_idle[m])
    );
  end

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Word the receiver should present for a byte driven MSB-first on the wire.
  function automatic logic [7:0] wire_to_word(input logic [7:0] w);
    logic [7:0] r;
`ifdef SPI_RX_LSB_FIRST_EN
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
`else
    r = w;
`endif
    return r;
  endfunction

  // One clock; outputs are observed on the falling edge.
  task automatic tick();
    logic pv, pacc;
    pv   = rx_valid;
    pacc = rx_valid && rx_ready;
    @(negedge clock);
    if (overrun)   overrun_n++;
    if (frame_err) frame_err_n++;
    if (rx_valid && (!pv || pacc)) begin
      chk("word_pending", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("rx_data", rx_data, exp_q.pop_front());
    end
    if (aux_on) begin
      for (int m = 1; m <= 3; m++) begin
        if (aux_valid[m]) begin
          chk("aux_word_pending", (aux_n[m] < aux_exp.size()), 1);
          if (aux_n[m] < aux_exp.size()) chk("aux_rx_data", aux_data[m], aux_exp[aux_n[m]]);
          aux_n[m]++;
        end
        if (aux_ovr[m] || aux_ferr[m]) aux_bad[m]++;
      end
    end
  endtask

  // One sck period: half period low then half high, relative to idle.
  task automatic send_bit(input logic b, input bit ready_on_done);
    mosi0 = b;
    repeat (4) tick();
    sck_base = 1'b1;
    mosi1    = b;
    if (ready_on_done) begin
      // Leading edge reaches the completion cycle 3 clocks later.
      repeat (3) tick();
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
    end else begin
      repeat (4) tick();
    end
    sck_base = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] w, input bit push, input bit ready_on_done);
    if (push) exp_q.push_back(wire_to_word(w));
    for (int i = 7; i >= 0; i--) send_bit(w[i], ready_on_done && (i == 0));
  endtask

  task automatic begin_frame();
    cs_n = 1'b0;
    repeat (4) tick();
  endtask

  task automatic end_frame();
    repeat (4) tick();
    cs_n = 1'b1;
    repeat (8) tick();
  endtask

  initial begin
    checks = 0; failures = 0; overrun_n = 0; frame_err_n = 0; aux_on = 1'b0;
    for (int m = 1; m <= 3; m++) begin aux_n[m] = 0; aux_bad[m] = 0; end
    rst = 1'b1; sck_base = 1'b0; cs_n = 1'b1; mosi0 = 1'b0; mosi1 = 1'b0; rx_ready = 1'b1;

    // Reset state
    repeat (3) tick();
    chk("reset_rx_data",   rx_data,   0);
    chk("reset_rx_valid",  rx_valid,  0);
    chk("reset_overrun",   overrun,   0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_bit_cnt",   bit_cnt,   0);
    chk("reset_idle",      idle,      1);
    rst = 1'b0;
    repeat (4) tick();

    // Mode 0, single word with rx_ready high
    begin_frame();
    chk("busy_idle", idle, 0);
    send_byte(8'hA5, 1'b1, 1'b0);
    end_frame();
    chk("a5_all_seen",  exp_q.size(), 0);
    chk("a5_bit_cnt",   bit_cnt, 8);
    chk("a5_frame_err", frame_err_n, 0);
    chk("a5_idle",      idle, 1);
    chk("a5_valid_off", rx_valid, 0);

    // Mode sweep: two words in one frame
    aux_exp = '{wire_to_word(8'h3C), wire_to_word(8'hC3)};
    aux_on  = 1'b1;
    begin_frame();
    send_byte(8'h3C, 1'b1, 1'b0);
    send_byte(8'hC3, 1'b1, 1'b0);
    end_frame();
    aux_on = 1'b0;
    chk("sweep_m0_all_seen", exp_q.size(), 0);
    chk("sweep_m0_bit_cnt",  bit_cnt, 16);
    for (int m = 1; m <= 3; m++) begin
      chk("sweep_words",   aux_n[m],    2);
      chk("sweep_bit_cnt", aux_cnt[m],  16);
      chk("sweep_errors",  aux_bad[m],  0);
      chk("sweep_idle",    aux_idle[m], 1);
    end

    // Overrun: consumer never ready during the frame
    rx_ready = 1'b0; overrun_n = 0;
    begin_frame();
    send_byte(8'h11, 1'b1, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    end_frame();
    chk("ovr_rx_data",  rx_data,   wire_to_word(8'h11));
    chk("ovr_rx_valid", rx_valid,  1);
    chk("ovr_pulses",   overrun_n, 1);
    chk("ovr_all_seen", exp_q.size(), 0);
    rx_ready = 1'b1;
    repeat (2) tick();
    chk("ovr_drained", rx_valid, 0);

    // rx_ready high in exactly the second completion cycle
    rx_ready = 1'b0; overrun_n = 0;
    begin_frame();
    send_byte(8'h11, 1'b1, 1'b0);
    send_byte(8'h22, 1'b1, 1'b1);
    end_frame();
    chk("rdy_rx_data",  rx_data,   wire_to_word(8'h22));
    chk("rdy_rx_valid", rx_valid,  1);
    chk("rdy_overrun",  overrun_n, 0);
    chk("rdy_all_seen", exp_q.size(), 0);
    rx_ready = 1'b1;
    repeat (2) tick();

    // Partial word: cs_n rises after 5 bits
    frame_err_n = 0;
    begin_frame();
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    end_frame();
    chk("ferr_pulses",  frame_err_n, 1);
    chk("ferr_valid",   rx_valid, 0);
    chk("ferr_bit_cnt", bit_cnt, 5);
    begin_frame();
    send_byte(8'h81, 1'b1, 1'b0);
    end_frame();
    chk("ferr_next_all_seen", exp_q.size(), 0);
    chk("ferr_next_count",    frame_err_n, 1);

    // Reset mid-word, then a clean frame
    begin_frame();
    for (int i = 7; i >= 4; i--) send_bit(logic'((8'h5A >> i) & 8'h01), 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_rx_data",   rx_data,   0);
    chk("mid_rst_rx_valid",  rx_valid,  0);
    chk("mid_rst_overrun",   overrun,   0);
    chk("mid_rst_frame_err", frame_err, 0);
    chk("mid_rst_bit_cnt",   bit_cnt,   0);
    chk("mid_rst_idle",      idle,      1);
    cs_n = 1'b1;
    repeat (4) tick();
    rst = 1'b0;
    repeat (4) tick();
    begin_frame();
    send_byte(8'h5A, 1'b1, 1'b0);
    end_frame();
    chk("post_rst_all_seen", exp_q.size(), 0);
    chk("post_rst_bit_cnt",  bit_cnt, 8);
    chk("post_rst_ferr",     frame_err_n, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_spi_rx_byte_phy
